// File: rtl/decode_unit.sv
// decode_unit: decode stage of an in-order pipeline.
// Reads the register file, bypasses results from MEM/WB (when enabled),
// detects read-after-write hazards against the in-flight stages, builds
// the immediates and registers a decoded operand bundle behind a
// valid/ready handshake towards execute.
module decode_unit #(
    parameter int XLEN   = 64,
    parameter int FWD_EN = 1
) (
    input  logic            CLK,
    input  logic            RESET,

    input  logic            de_valid,
    output logic            de_ready,
    input  logic [XLEN-1:0] de_pc,
    input  logic [31:0]     de_ir,

    input  logic            exe_v,
    input  logic            mem_v,
    input  logic            wb_v,
    input  logic [4:0]      exe_dr,
    input  logic [4:0]      mem_dr,
    input  logic [4:0]      wb_dr,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_we,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_alu1,
    output logic [XLEN-1:0] out_alu2,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_maddr,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Link offset placed in alu2 for JAL/JALR so execute computes pc+4.
    localparam logic [XLEN-1:0] LINK_STEP = XLEN'(4);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;

    logic [XLEN-1:0] rf [32];

    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    logic            use_rs1;
    logic            use_rs2;
    logic            rs1_exe_hit;
    logic            rs2_exe_hit;
    logic            rs1_late_hit;
    logic            rs2_late_hit;
    logic            hazard;
    logic            accept;

    logic [XLEN-1:0] nxt_alu1;
    logic [XLEN-1:0] nxt_alu2;
    logic [XLEN-1:0] nxt_target;
    logic [XLEN-1:0] nxt_maddr;
    logic            nxt_illegal;
    logic [XLEN-1:0] jalr_sum;

    assign opcode = de_ir[6:0];
    assign rs1    = de_ir[19:15];
    assign rs2    = de_ir[24:20];

    // Register file: cleared on reset, x0 is never written.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_we && (wb_dr != 5'd0)) begin
            rf[wb_dr] <= wb_data;
        end
    end

    // Register file read ports with write-before-read on the WB port.
    always_comb begin
        rs1_rf = rf[rs1];
        rs2_rf = rf[rs2];
        if (wb_we && (wb_dr == rs1)) rs1_rf = wb_data;
        if (wb_we && (wb_dr == rs2)) rs2_rf = wb_data;
        if (rs1 == 5'd0) rs1_rf = '0;
        if (rs2 == 5'd0) rs2_rf = '0;
    end

    // Operand bypass: youngest producer wins (MEM, then WB, then regfile).
    always_comb begin
        rs1_val = rs1_rf;
        rs2_val = rs2_rf;
        if ((FWD_EN != 0) && (rs1 != 5'd0)) begin
            if (wb_v && (wb_dr == rs1))   rs1_val = wb_data;
            if (mem_v && (mem_dr == rs1)) rs1_val = mem_data;
        end
        if ((FWD_EN != 0) && (rs2 != 5'd0)) begin
            if (wb_v && (wb_dr == rs2))   rs2_val = wb_data;
            if (mem_v && (mem_dr == rs2)) rs2_val = mem_data;
        end
    end

    // Immediates, all sign-extended from instruction bit 31.
    always_comb begin
        imm_i = XLEN'($signed(de_ir[31:20]));
        imm_s = XLEN'($signed({de_ir[31:25], de_ir[11:7]}));
        imm_b = XLEN'($signed({de_ir[31], de_ir[7], de_ir[30:25], de_ir[11:8], 1'b0}));
        imm_u = XLEN'($signed({de_ir[31:12], 12'b0}));
        imm_j = XLEN'($signed({de_ir[31], de_ir[19:12], de_ir[20], de_ir[30:21], 1'b0}));
    end

    // Which source fields are real register reads for this opcode.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: use_rs1 = 1'b1;
            OPC_STORE, OPC_OP, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard detection; x0 never creates a dependency.
    always_comb begin
        rs1_exe_hit  = use_rs1 && (rs1 != 5'd0) && exe_v && (exe_dr == rs1);
        rs2_exe_hit  = use_rs2 && (rs2 != 5'd0) && exe_v && (exe_dr == rs2);
        rs1_late_hit = use_rs1 && (rs1 != 5'd0) &&
                       ((mem_v && (mem_dr == rs1)) || (wb_v && (wb_dr == rs1)));
        rs2_late_hit = use_rs2 && (rs2 != 5'd0) &&
                       ((mem_v && (mem_dr == rs2)) || (wb_v && (wb_dr == rs2)));
        hazard = rs1_exe_hit || rs2_exe_hit;
        if (FWD_EN == 0) begin
            hazard = hazard || rs1_late_hit || rs2_late_hit;
        end
    end

    // Handshake: held off by reset, hazards, flush and a stalled output slot.
    always_comb begin
        de_ready = !RESET && !hazard && !flush && (!out_valid || out_ready);
        accept   = de_valid && de_ready;
    end

    // Operand/address formation per opcode; undefined fields stay zero.
    always_comb begin
        nxt_alu1    = '0;
        nxt_alu2    = '0;
        nxt_target  = '0;
        nxt_maddr   = '0;
        nxt_illegal = 1'b0;
        jalr_sum    = rs1_val + imm_i;
        case (opcode)
            OPC_LOAD: begin
                nxt_alu1  = rs1_val;
                nxt_alu2  = imm_i;
                nxt_maddr = rs1_val + imm_i;
            end
            OPC_STORE: begin
                nxt_alu1  = rs1_val;
                nxt_alu2  = rs2_val;
                nxt_maddr = rs1_val + imm_s;
            end
            OPC_OP: begin
                nxt_alu1 = rs1_val;
                nxt_alu2 = rs2_val;
            end
            OPC_OP_IMM: begin
                nxt_alu1 = rs1_val;
                nxt_alu2 = imm_i;
            end
            OPC_BRANCH: begin
                nxt_alu1   = rs1_val;
                nxt_alu2   = rs2_val;
                nxt_target = de_pc + imm_b;
            end
            OPC_LUI: begin
                nxt_alu1 = imm_u;
            end
            OPC_AUIPC: begin
                nxt_alu1 = de_pc;
                nxt_alu2 = imm_u;
            end
            OPC_JAL: begin
                nxt_alu1   = de_pc;
                nxt_alu2   = LINK_STEP;
                nxt_target = de_pc + imm_j;
            end
            OPC_JALR: begin
                nxt_alu1   = de_pc;
                nxt_alu2   = LINK_STEP;
                nxt_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: begin
                nxt_illegal = 1'b1;
            end
        endcase
    end

    // Output register: flush beats accept; fields hold unless accepting.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid   <= 1'b0;
            out_ir      <= '0;
            out_alu1    <= '0;
            out_alu2    <= '0;
            out_target  <= '0;
            out_maddr   <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_ir      <= de_ir;
            out_alu1    <= nxt_alu1;
            out_alu2    <= nxt_alu2;
            out_target  <= nxt_target;
            out_maddr   <= nxt_maddr;
            out_illegal <= nxt_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: directed scenarios plus a randomized run against
// a behavioural decode model. Three instances share stimulus: 64-bit with
// bypass, 64-bit without bypass, and 32-bit with bypass.
module tb_decode_unit;

    logic        CLK;
    logic        RESET;
    logic        de_valid;
    logic [63:0] de_pc;
    logic [31:0] de_ir;
    logic        exe_v, mem_v, wb_v, wb_we, flush, out_ready;
    logic [4:0]  exe_dr, mem_dr, wb_dr;
    logic [63:0] mem_data, wb_data;

    logic        de_ready, out_valid, out_illegal;
    logic [31:0] out_ir;
    logic [63:0] out_alu1, out_alu2, out_target, out_maddr;

    logic        nf_de_ready, nf_out_valid, nf_out_illegal;
    logic [31:0] nf_out_ir;
    logic [63:0] nf_out_alu1, nf_out_alu2, nf_out_target, nf_out_maddr;

    logic        n32_de_ready, n32_out_valid, n32_out_illegal;
    logic [31:0] n32_out_ir;
    logic [31:0] n32_out_alu1, n32_out_alu2, n32_out_target, n32_out_maddr;

    int total = 0;
    int bad   = 0;

    logic [63:0] ref_rf [32];

    decode_unit #(.XLEN(64), .FWD_EN(1)) dut (
        .CLK(CLK), .RESET(RESET), .de_valid(de_valid), .de_ready(de_ready),
        .de_pc(de_pc), .de_ir(de_ir), .exe_v(exe_v), .mem_v(mem_v), .wb_v(wb_v),
        .exe_dr(exe_dr), .mem_dr(mem_dr), .wb_dr(wb_dr), .mem_data(mem_data),
        .wb_data(wb_data), .wb_we(wb_we), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ir(out_ir), .out_alu1(out_alu1),
        .out_alu2(out_alu2), .out_target(out_target), .out_maddr(out_maddr),
        .out_illegal(out_illegal));

    decode_unit #(.XLEN(64), .FWD_EN(0)) dut_nf (
        .CLK(CLK), .RESET(RESET), .de_valid(de_valid), .de_ready(nf_de_ready),
        .de_pc(de_pc), .de_ir(de_ir), .exe_v(exe_v), .mem_v(mem_v), .wb_v(wb_v),
        .exe_dr(exe_dr), .mem_dr(mem_dr), .wb_dr(wb_dr), .mem_data(mem_data),
        .wb_data(wb_data), .wb_we(wb_we), .flush(flush), .out_valid(nf_out_valid),
        .out_ready(out_ready), .out_ir(nf_out_ir), .out_alu1(nf_out_alu1),
        .out_alu2(nf_out_alu2), .out_target(nf_out_target), .out_maddr(nf_out_maddr),
        .out_illegal(nf_out_illegal));

    decode_unit #(.XLEN(32), .FWD_EN(1)) dut32 (
        .CLK(CLK), .RESET(RESET), .de_valid(de_valid), .de_ready(n32_de_ready),
        .de_pc(de_pc[31:0]), .de_ir(de_ir), .exe_v(exe_v), .mem_v(mem_v), .wb_v(wb_v),
        .exe_dr(exe_dr), .mem_dr(mem_dr), .wb_dr(wb_dr), .mem_data(mem_data[31:0]),
        .wb_data(wb_data[31:0]), .wb_we(wb_we), .flush(flush), .out_valid(n32_out_valid),
        .out_ready(out_ready), .out_ir(n32_out_ir), .out_alu1(n32_out_alu1),
        .out_alu2(n32_out_alu2), .out_target(n32_out_target), .out_maddr(n32_out_maddr),
        .out_illegal(n32_out_illegal));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        de_valid = 0; de_pc = '0; de_ir = '0;
        exe_v = 0; mem_v = 0; wb_v = 0; wb_we = 0; flush = 0; out_ready = 1;
        exe_dr = '0; mem_dr = '0; wb_dr = '0; mem_data = '0; wb_data = '0;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [63:0] v);
        wb_we = 1; wb_dr = r; wb_data = v;
        tick();
        wb_we = 0; wb_dr = '0; wb_data = '0;
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        return 64'($signed(v << (64 - bits)) >>> (64 - bits));
    endfunction

    function automatic logic [63:0] src_val(input logic [4:0] r);
        if (r == 0) return 64'd0;
        if (mem_v && mem_dr == r) return mem_data;
        if (wb_v && wb_dr == r) return wb_data;
        if (wb_we && wb_dr == r) return wb_data;
        return ref_rf[r];
    endfunction

    function automatic void model(input logic [63:0] pc, input logic [31:0] ir,
                                  output logic [63:0] a1, output logic [63:0] a2,
                                  output logic [63:0] tg, output logic [63:0] ma,
                                  output logic il, output logic hz);
        logic [4:0]  r1, r2;
        logic [63:0] v1, v2, ii, is, ib, iu, ij;
        logic        u1, u2;
        r1 = ir[19:15]; r2 = ir[24:20];
        v1 = src_val(r1); v2 = src_val(r2);
        ii = sx(64'(ir[31:20]), 12);
        is = sx(64'({ir[31:25], ir[11:7]}), 12);
        ib = sx(64'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}), 13);
        iu = sx(64'({ir[31:12], 12'b0}), 32);
        ij = sx(64'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}), 21);
        a1 = 0; a2 = 0; tg = 0; ma = 0; il = 0; u1 = 0; u2 = 0;
        case (ir[6:0])
            7'h03: begin u1 = 1; a1 = v1; a2 = ii; ma = v1 + ii; end
            7'h23: begin u1 = 1; u2 = 1; a1 = v1; a2 = v2; ma = v1 + is; end
            7'h33: begin u1 = 1; u2 = 1; a1 = v1; a2 = v2; end
            7'h13: begin u1 = 1; a1 = v1; a2 = ii; end
            7'h63: begin u1 = 1; u2 = 1; a1 = v1; a2 = v2; tg = pc + ib; end
            7'h37: begin a1 = iu; end
            7'h17: begin a1 = pc; a2 = iu; end
            7'h6F: begin a1 = pc; a2 = 64'd4; tg = pc + ij; end
            7'h67: begin u1 = 1; a1 = pc; a2 = 64'd4; tg = (v1 + ii) & ~64'd1; end
            default: il = 1;
        endcase
        hz = (u1 && r1 != 0 && exe_v && exe_dr == r1) ||
             (u2 && r2 != 0 && exe_v && exe_dr == r2);
    endfunction

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        RESET = 1; de_valid = 1; de_ir = 32'h00100513; de_pc = 64'h40;
        for (int c = 0; c < 2; c++) begin
            #4;
            total++; if (de_ready !== 1'b0) begin bad++; $display("FAIL reset_de_ready got=%0b want=0", de_ready); end
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
            total++;
            if ({out_ir, out_alu1, out_alu2, out_target, out_maddr, out_illegal} !== '0) begin
                bad++; $display("FAIL reset_outs got ir=%h a1=%h a2=%h t=%h m=%h il=%b want all 0",
                                out_ir, out_alu1, out_alu2, out_target, out_maddr, out_illegal);
            end
        end
        RESET = 0; de_valid = 0;
        tick();
    endtask

    task automatic test_load();
        write_reg(5'd1, 64'h10);
        de_valid = 1; de_pc = 64'h100; de_ir = 32'hFF80B103; // ld x2,-8(x1)
        #4;
        total++; if (de_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%0b want=1", de_ready); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%0b want=1", out_valid); end
        total++; if (out_maddr !== 64'h8) begin bad++; $display("FAIL load_maddr got=%h want=8", out_maddr); end
        total++; if (out_alu2 !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL load_alu2 got=%h want=fffffffffffffff8", out_alu2); end
        total++; if (out_alu1 !== 64'h10) begin bad++; $display("FAIL load_alu1 got=%h want=10", out_alu1); end
        total++; if (n32_out_alu2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL load32_alu2 got=%h want=fffffff8", n32_out_alu2); end
        de_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL load_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_hazard();
        write_reg(5'd1, 64'd3);
        write_reg(5'd2, 64'd4);
        de_valid = 1; de_ir = 32'h002081B3; exe_v = 1; exe_dr = 5'd2; // add x3,x1,x2
        for (int c = 0; c < 3; c++) begin
            #4;
            total++; if (de_ready !== 1'b0) begin bad++; $display("FAIL hazard_stall got=%0b want=0", de_ready); end
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hazard_noacc got=%0b want=0", out_valid); end
        end
        exe_v = 0;
        #4;
        total++; if (de_ready !== 1'b1) begin bad++; $display("FAIL hazard_release got=%0b want=1", de_ready); end
        tick();
        de_valid = 0;
        total++; if (out_valid !== 1'b1 || out_alu1 !== 64'd3 || out_alu2 !== 64'd4) begin
            bad++; $display("FAIL hazard_accept got v=%0b a1=%h a2=%h want v=1 a1=3 a2=4", out_valid, out_alu1, out_alu2);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hazard_single got=%0b want=0", out_valid); end
    endtask

    task automatic test_forward();
        write_reg(5'd1, 64'h77);
        de_valid = 1; de_ir = 32'h00008293; // addi x5,x1,0
        mem_v = 1; mem_dr = 5'd1; mem_data = 64'h55;
        wb_v = 1; wb_dr = 5'd1; wb_data = 64'h66;
        #4;
        total++; if (de_ready !== 1'b1) begin bad++; $display("FAIL fwd_nostall got=%0b want=1", de_ready); end
        total++; if (nf_de_ready !== 1'b0) begin bad++; $display("FAIL nofwd_mem_stall got=%0b want=0", nf_de_ready); end
        tick();
        total++; if (out_alu1 !== 64'h55) begin bad++; $display("FAIL fwd_mem got=%h want=55", out_alu1); end
        mem_v = 0;
        #4;
        total++; if (nf_de_ready !== 1'b0) begin bad++; $display("FAIL nofwd_wb_stall got=%0b want=0", nf_de_ready); end
        tick();
        total++; if (out_alu1 !== 64'h66) begin bad++; $display("FAIL fwd_wb got=%h want=66", out_alu1); end
        wb_v = 0;
        #4;
        total++; if (nf_de_ready !== 1'b1) begin bad++; $display("FAIL nofwd_clear got=%0b want=1", nf_de_ready); end
        tick();
        total++; if (out_alu1 !== 64'h77) begin bad++; $display("FAIL fwd_rf got=%h want=77", out_alu1); end
        de_ir = 32'h00040493; wb_we = 1; wb_dr = 5'd8; wb_data = 64'h1234; // addi x9,x8,0
        tick();
        total++; if (out_alu1 !== 64'h1234) begin bad++; $display("FAIL wbr got=%h want=1234", out_alu1); end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        de_valid = 1; de_ir = 32'h00100513; out_ready = 0;
        tick();
        total++; if (out_valid !== 1'b1 || out_ir !== 32'h00100513) begin
            bad++; $display("FAIL bp_first got v=%0b ir=%h want v=1 ir=00100513", out_valid, out_ir);
        end
        de_ir = 32'h00200593;
        for (int c = 0; c < 3; c++) begin
            #4;
            total++; if (de_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b want=0", de_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_ir !== 32'h00100513 || out_alu2 !== 64'd1) begin
                bad++; $display("FAIL bp_hold got v=%0b ir=%h a2=%h want v=1 ir=00100513 a2=1", out_valid, out_ir, out_alu2);
            end
        end
        out_ready = 1;
        #4;
        total++; if (de_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", de_ready); end
        tick();
        total++; if (out_ir !== 32'h00200593 || out_alu2 !== 64'd2) begin
            bad++; $display("FAIL bp_next got ir=%h a2=%h want ir=00200593 a2=2", out_ir, out_alu2);
        end
        de_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        de_valid = 1; de_ir = 32'h00100513; flush = 1;
        #4;
        total++; if (de_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b want=0", de_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_accept got=%0b want=0", out_valid); end
        flush = 0; out_ready = 0;
        tick();
        flush = 1; de_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_held got=%0b want=0", out_valid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0_illegal();
        de_valid = 1; de_ir = 32'h00500313; exe_v = 1; exe_dr = 5'd0; // addi x6,x0,5
        #4;
        total++; if (de_ready !== 1'b1) begin bad++; $display("FAIL x0_nostall got=%0b want=1", de_ready); end
        tick();
        total++; if (out_alu1 !== 64'd0 || out_alu2 !== 64'd5) begin
            bad++; $display("FAIL x0_ops got a1=%h a2=%h want a1=0 a2=5", out_alu1, out_alu2);
        end
        exe_v = 0; de_ir = 32'h0010807F; de_pc = 64'h200;
        tick();
        total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin
            bad++; $display("FAIL illegal_flag got v=%0b il=%0b want v=1 il=1", out_valid, out_illegal);
        end
        total++; if ({out_alu1, out_alu2, out_target, out_maddr} !== '0) begin
            bad++; $display("FAIL illegal_zero got a1=%h a2=%h t=%h m=%h want 0", out_alu1, out_alu2, out_target, out_maddr);
        end
        de_valid = 0;
        tick();
    endtask

    task automatic test_jal_wrap();
        de_valid = 1; de_pc = 64'hFFFF_FFFF_FFFF_FFFC; de_ir = 32'h0080006F; // jal x0,+8
        tick();
        total++; if (n32_out_target !== 32'h4) begin bad++; $display("FAIL jal32_target got=%h want=4", n32_out_target); end
        total++; if (n32_out_alu1 !== 32'hFFFF_FFFC || n32_out_alu2 !== 32'd4) begin
            bad++; $display("FAIL jal32_ops got a1=%h a2=%h want a1=fffffffc a2=4", n32_out_alu1, n32_out_alu2);
        end
        total++; if (out_target !== 64'h4) begin bad++; $display("FAIL jal64_target got=%h want=4", out_target); end
        de_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        write_reg(5'd4, 64'hABCD);
        de_valid = 1; de_ir = 32'h00020393; // addi x7,x4,0
        tick();
        total++; if (out_alu1 !== 64'hABCD) begin bad++; $display("FAIL rmid_pre got=%h want=abcd", out_alu1); end
        RESET = 1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", out_valid); end
        RESET = 0; de_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0b want=0", out_valid); end
        de_valid = 1;
        tick();
        total++; if (out_valid !== 1'b1 || out_alu1 !== 64'd0) begin
            bad++; $display("FAIL rmid_rfclr got v=%0b a1=%h want v=1 a1=0", out_valid, out_alu1);
        end
        de_valid = 0;
        tick();
    endtask

    // ---------------- randomized run ----------------
    task automatic test_random();
        logic [6:0]  opcs [10];
        logic [31:0] ir;
        logic [63:0] a1, a2, tg, ma;
        logic        il, hz, exp_rdy, acc;
        logic        e_valid, e_il;
        logic [31:0] e_ir;
        logic [63:0] e_a1, e_a2, e_tg, e_ma;
        opcs = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        idle_inputs();
        RESET = 1;
        tick(); tick();
        RESET = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        e_valid = 0; e_il = 0; e_ir = '0; e_a1 = '0; e_a2 = '0; e_tg = '0; e_ma = '0;
        for (int n = 0; n < 600; n++) begin
            ir = $urandom;
            ir[6:0]   = opcs[$urandom_range(0, 9)];
            ir[19:15] = 5'($urandom_range(0, 7));
            ir[24:20] = 5'($urandom_range(0, 7));
            de_ir     = ir;
            de_valid  = ($urandom_range(0, 3) != 0);
            de_pc     = {$urandom, $urandom};
            exe_v = ($urandom_range(0, 3) == 0); exe_dr = 5'($urandom_range(0, 7));
            mem_v = ($urandom_range(0, 2) == 0); mem_dr = 5'($urandom_range(0, 7));
            wb_v  = ($urandom_range(0, 2) == 0); wb_dr  = 5'($urandom_range(0, 7));
            mem_data = {$urandom, $urandom};
            wb_data  = {$urandom, $urandom};
            wb_we    = ($urandom_range(0, 1) == 1);
            flush    = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            model(de_pc, de_ir, a1, a2, tg, ma, il, hz);
            exp_rdy = !hz && !flush && (!e_valid || out_ready);
            acc = de_valid && exp_rdy;
            #4;
            total++; if (de_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b want=%0b", n, de_ready, exp_rdy); end
            total++; if (n32_de_ready !== exp_rdy) begin bad++; $display("FAIL rnd32_ready n=%0d got=%0b want=%0b", n, n32_de_ready, exp_rdy); end
            if (flush) e_valid = 0;
            else if (acc) begin
                e_valid = 1; e_ir = de_ir; e_a1 = a1; e_a2 = a2; e_tg = tg; e_ma = ma; e_il = il;
            end else if (out_ready) e_valid = 0;
            if (wb_we && wb_dr != 0) ref_rf[wb_dr] = wb_data;
            tick();
            total++; if (out_valid !== e_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%0b want=%0b", n, out_valid, e_valid); end
            total++; if (n32_out_valid !== e_valid) begin bad++; $display("FAIL rnd32_valid n=%0d got=%0b want=%0b", n, n32_out_valid, e_valid); end
            if (e_valid) begin
                total++;
                if (out_ir !== e_ir || out_alu1 !== e_a1 || out_alu2 !== e_a2 ||
                    out_target !== e_tg || out_maddr !== e_ma || out_illegal !== e_il) begin
                    bad++;
                    $display("FAIL rnd_outs n=%0d ir=%h got a1=%h a2=%h t=%h m=%h il=%b want a1=%h a2=%h t=%h m=%h il=%b",
                             n, e_ir, out_alu1, out_alu2, out_target, out_maddr, out_illegal,
                             e_a1, e_a2, e_tg, e_ma, e_il);
                end
                total++;
                if (n32_out_alu1 !== e_a1[31:0] || n32_out_alu2 !== e_a2[31:0] ||
                    n32_out_target !== e_tg[31:0] || n32_out_maddr !== e_ma[31:0] ||
                    n32_out_illegal !== e_il) begin
                    bad++;
                    $display("FAIL rnd32_outs n=%0d ir=%h got a1=%h a2=%h t=%h m=%h want a1=%h a2=%h t=%h m=%h",
                             n, e_ir, n32_out_alu1, n32_out_alu2, n32_out_target, n32_out_maddr,
                             e_a1[31:0], e_a2[31:0], e_tg[31:0], e_ma[31:0]);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        RESET = 1;
        tick();
        test_reset();
        test_load();
        test_hazard();
        test_forward();
        test_backpressure();
        test_flush();
        test_x0_illegal();
        test_jal_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter FWD_EN, default 1, meaning 1 enables MEM/WB bypass and 0 stalls on every hazard.
REQ-003 SHALL have port CLK, input, 1, clock; RESET, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port de_valid, input, 1, fetch holds a valid instruction.
REQ-005 SHALL have port de_ready, output, 1, decode accepts this cycle.
REQ-006 SHALL have ports de_pc (input, XLEN, instruction address) and de_ir (input, 32, instruction).
REQ-007 SHALL have ports exe_v/mem_v/wb_v (inputs, 1) and exe_dr/mem_dr/wb_dr (inputs, 5), giving the valid flag and destination of each downstream stage.
REQ-008 SHALL have ports mem_data and wb_data (inputs, XLEN), the result values of MEM and WB.
REQ-009 SHALL have port wb_we, input, 1, register-file write strobe, which writes wb_data to wb_dr.
REQ-010 SHALL have port flush, input, 1, discard decode output.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1, the execute handshake.
REQ-012 SHALL have outputs out_ir (32), out_alu1, out_alu2, out_target and out_maddr (each XLEN), and out_illegal (1).

Function
REQ-013 SHALL contain a 32xXLEN register file in which x0 reads 0 and writes to x0 are ignored.
REQ-014 SHALL return wb_data on a same-cycle register-file read of wb_dr when wb_we=1 and wb_dr!=0 (write-before-read).
REQ-015 SHALL treat rs1 as used only by LOAD, STORE, OP, OP-IMM, BRANCH and JALR, and rs2 as used only by STORE, OP and BRANCH.
REQ-016 SHALL ignore any source equal to x0 in hazard checks.
REQ-017 SHALL raise hazard when a used source matches exe_dr with exe_v=1.
REQ-018 SHALL raise hazard on a used-source match with mem_dr (mem_v=1) or wb_dr (wb_v=1) only when FWD_EN=0.
REQ-019 SHALL, when FWD_EN=1, select the operand from the youngest match: MEM over WB over register file.
REQ-020 SHALL drive de_ready = !hazard && !flush && (!out_valid || out_ready), combinationally.
REQ-021 SHALL accept an instruction when de_valid && de_ready, loading all out_* registers on that CLK edge, so latency is 1 cycle.
REQ-022 SHALL clear out_valid when out_ready=1 and no accept occurs, and SHALL hold all out_* stable while out_valid && !out_ready.
REQ-023 SHALL give flush priority over accept: out_valid is 0 after the edge and nothing is accepted that cycle.
REQ-024 SHALL build immediates sign-extended to XLEN from bit 31 in I, S, B, U and J formats.
REQ-025 SHALL decode LOAD as alu1=rs1, alu2=immI, maddr=rs1+immI.
REQ-026 SHALL decode STORE as alu1=rs1, alu2=rs2, maddr=rs1+immS.
REQ-027 SHALL decode OP as alu1=rs1, alu2=rs2, and OP-IMM as alu1=rs1, alu2=immI.
REQ-028 SHALL decode BRANCH as alu1=rs1, alu2=rs2, target=pc+immB.
REQ-029 SHALL decode LUI as alu1=immU, alu2=0, and AUIPC as alu1=pc, alu2=immU.
REQ-030 SHALL decode JAL as alu1=pc, alu2=4, target=pc+immJ.
REQ-031 SHALL decode JALR as alu1=pc, alu2=4, target=(rs1+immI) with bit0 cleared.
REQ-032 SHALL set out_target and out_maddr to 0 where the opcode does not define them.
REQ-033 SHALL, on any other opcode, accept normally with out_illegal=1 and alu1, alu2, target and maddr all 0.
REQ-034 SHALL compute all address sums modulo 2^XLEN, so wrap-around is silent.

Reset
REQ-035 SHALL, while RESET=1, clear out_valid, out_illegal, out_ir, out_alu1, out_alu2, out_target and out_maddr to 0, and keep de_ready=0.
REQ-036 SHALL clear all 32 registers to 0 on reset.
REQ-037 SHALL discard any in-flight accept when reset is asserted mid-operation, with no out_valid on the following cycle.

Verification
REQ-038 SHALL be verified by: XLEN=64, x1=0x10, LOAD x2,-8(x1) -> next cycle out_valid=1, out_maddr=0x8, out_alu2=0xFFFF_FFFF_FFFF_FFF8.
REQ-039 SHALL be verified by: OP x3=x1+x2 with exe_v=1, exe_dr=2 -> de_ready=0 until exe_v drops, then one accept.
REQ-040 SHALL be verified by: FWD_EN=1, mem_v=1, mem_dr=1, mem_data=0x55, wb_v=1, wb_dr=1, wb_data=0x66 -> out_alu1=0x55, no stall; FWD_EN=0 -> stall.
REQ-041 SHALL be verified by: out_ready=0 for 3 cycles with de_valid=1 -> out_* unchanged, de_ready=0; out_ready=1 -> next instruction accepted.
REQ-042 SHALL be verified by: flush=1 coincident with accept -> out_valid=0 next cycle.
REQ-043 SHALL be verified by: rs1=x0 with exe_dr=0, exe_v=1 -> no stall; opcode 0x7F -> out_illegal=1.
REQ-044 SHALL be verified by: XLEN=32, JAL at pc=0xFFFF_FFFC with imm=+8 -> out_target=0x4.
